// File: rtl/ps2_cmd_queue_if.sv
// ps2_cmd_queue_if
//   Bundles the scan-code input strobe, the event FIFO handshake and the
//   status outputs of ps2_cmd_queue.
//   master: keyboard/consumer side (drives code_in, code_valid, ev_ready)
//   slave : ps2_cmd_queue side  (drives ev_data, ev_valid, held, last_code,
//           overflow, ovf_cnt)
interface ps2_cmd_queue_if;
  logic [7:0]  code_in;
  logic        code_valid;
  logic [12:0] ev_data;
  logic        ev_valid;
  logic        ev_ready;
  logic [5:0]  held;
  logic [15:0] last_code;
  logic        overflow;
  logic [7:0]  ovf_cnt;

  modport master (
    output code_in, code_valid, ev_ready,
    input  ev_data, ev_valid, held, last_code, overflow, ovf_cnt
  );

  modport slave (
    input  code_in, code_valid, ev_ready,
    output ev_data, ev_valid, held, last_code, overflow, ovf_cnt
  );
endinterface

// File: rtl/ps2_cmd_queue.sv
// ps2_cmd_queue
//   PS/2 scan-code decoder (make / F0 break / E0 extended) feeding a command
//   classifier, repeat filter and event FIFO.
//   Ports:
//     clk50 : system clock
//     RST   : asynchronous active-high reset
//     bus   : ps2_cmd_queue_if.slave
//             code_in/code_valid  scan-code byte strobe
//             ev_data/ev_valid/ev_ready  head event {brk, ext, code, cmd}
//             held       held state of cmds 1..6 (bit k-1 = cmd k)
//             last_code  {7'h00, ext, code} of the last completed make
//             overflow   sticky drop-on-full flag
//             ovf_cnt    saturating drop-on-full count
//
//   state   | meaning
//   IDLE    | no prefix pending
//   EXT     | E0 seen, next code byte is an extended make
//   BRK     | F0 seen, next code byte is a normal break
//   EXT_BRK | E0 F0 seen, next code byte is an extended break
module ps2_cmd_queue #(
  parameter int DEPTH         = 8,
  parameter int EMIT_BREAK    = 0,
  parameter int FILTER_REPEAT = 1,
  parameter int CMD_ONLY      = 1
) (
  input logic            clk50,
  input logic            RST,
  ps2_cmd_queue_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t        state;
  logic [12:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [5:0]    held_q;
  logic [15:0]   last_q;
  logic          ovf_q;
  logic [7:0]    cnt_q;

  logic       is_e0, is_f0, done, ev_brk, ev_ext;
  logic [2:0] cmd;
  logic [5:0] cmd_mask;
  logic       keep, full, pop, wr_en, drop;

  always_comb begin
    is_e0  = (bus.code_in == 8'hE0);
    is_f0  = (bus.code_in == 8'hF0);
    done   = bus.code_valid && !is_e0 && !is_f0;
    ev_brk = (state == BRK) || (state == EXT_BRK);
    ev_ext = (state == EXT) || (state == EXT_BRK);

    case (bus.code_in)
      8'h1D, 8'h75: cmd = 3'd1;
      8'h1B, 8'h72: cmd = 3'd2;
      8'h1C, 8'h6B: cmd = 3'd3;
      8'h23, 8'h74: cmd = 3'd4;
      8'h5A:        cmd = 3'd5;
      8'h76:        cmd = 3'd6;
      default:      cmd = 3'd0;
    endcase

    case (cmd)
      3'd1:    cmd_mask = 6'b000001;
      3'd2:    cmd_mask = 6'b000010;
      3'd3:    cmd_mask = 6'b000100;
      3'd4:    cmd_mask = 6'b001000;
      3'd5:    cmd_mask = 6'b010000;
      3'd6:    cmd_mask = 6'b100000;
      default: cmd_mask = 6'b000000;
    endcase

    // Repeat filter looks at held state before this event updates it.
    keep = done;
    if (ev_brk && EMIT_BREAK == 0) keep = 1'b0;
    if (cmd == 3'd0 && CMD_ONLY != 0) keep = 1'b0;
    if (!ev_brk && (held_q & cmd_mask) != 6'b0 && FILTER_REPEAT != 0) keep = 1'b0;

    full  = (count == FULL_CNT);
    pop   = (count != '0) && bus.ev_ready;
    // A pop in the same cycle frees the slot, so full+push+pop still writes.
    wr_en = keep && (!full || pop);
    drop  = keep && full && !pop;
  end

  always_ff @(posedge clk50 or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      held_q <= '0;
      last_q <= '0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (bus.code_valid) begin
        if (is_e0)
          state <= EXT;
        else if (is_f0)
          state <= (state == EXT) ? EXT_BRK : BRK;
        else
          state <= IDLE;

        if (done) begin
          if (ev_brk) begin
            held_q <= held_q & ~cmd_mask;
          end else begin
            held_q <= held_q | cmd_mask;
            last_q <= {7'h00, ev_ext, bus.code_in};
          end
        end
      end

      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;

      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (drop) begin
        ovf_q <= 1'b1;
        if (cnt_q != 8'hFF) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: contents are only observed while count != 0.
  always_ff @(posedge clk50) begin
    if (wr_en) mem[wr_ptr] <= {ev_brk, ev_ext, bus.code_in, cmd};
  end

  assign bus.ev_data   = mem[rd_ptr];
  assign bus.ev_valid  = (count != '0);
  assign bus.held      = held_q;
  assign bus.last_code = last_q;
  assign bus.overflow  = ovf_q;
  assign bus.ovf_cnt   = cnt_q;

endmodule

// File: tb/tb_ps2_cmd_queue.sv
// tb_ps2_cmd_queue
//   Two ps2_cmd_queue instances with different parameter sets share one
//   scan-code stream. A reference model predicts each instance's events and
//   status; a negedge monitor compares DUT outputs and pops expected events
//   on every handshake.
`timescale 1ns/1ps
module tb_ps2_cmd_queue;

  logic clk50 = 1'b0;
  logic RST   = 1'b1;
  always #5 clk50 = ~clk50;

  ps2_cmd_queue_if bus_a();
  ps2_cmd_queue_if bus_b();

  ps2_cmd_queue #(.DEPTH(8), .EMIT_BREAK(0), .FILTER_REPEAT(1), .CMD_ONLY(1)) u_a (
    .clk50(clk50), .RST(RST), .bus(bus_a.slave));
  ps2_cmd_queue #(.DEPTH(4), .EMIT_BREAK(1), .FILTER_REPEAT(0), .CMD_ONLY(0)) u_b (
    .clk50(clk50), .RST(RST), .bus(bus_b.slave));

  int cfg_depth[2] = '{8, 4};
  bit cfg_eb[2]    = '{1'b0, 1'b1};
  bit cfg_fr[2]    = '{1'b1, 1'b0};
  bit cfg_co[2]    = '{1'b1, 1'b0};

  int n_checks = 0;
  int n_fail   = 0;

  logic [12:0] exp_q0[$];
  logic [12:0] exp_q1[$];
  int          m_occ[2];
  bit          m_ext[2], m_brk[2];
  logic [5:0]  m_held[2];
  logic [15:0] m_last[2];
  bit          m_ovf[2];
  int          m_cnt[2];
  int          hs_cnt[2] = '{0, 0};
  bit          prev_hold[2];
  logic [12:0] prev_d[2];
  bit          rdy0, rdy1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [2:0] ref_cmd(logic [7:0] c);
    case (c)
      8'h1D, 8'h75: return 3'd1;
      8'h1B, 8'h72: return 3'd2;
      8'h1C, 8'h6B: return 3'd3;
      8'h23, 8'h74: return 3'd4;
      8'h5A:        return 3'd5;
      8'h76:        return 3'd6;
      default:      return 3'd0;
    endcase
  endfunction

  function automatic void model_reset();
    exp_q0.delete();
    exp_q1.delete();
    for (int i = 0; i < 2; i++) begin
      m_occ[i] = 0; m_ext[i] = 0; m_brk[i] = 0; m_held[i] = '0;
      m_last[i] = '0; m_ovf[i] = 0; m_cnt[i] = 0; prev_hold[i] = 0;
    end
  endfunction

  // Effect of one rising edge on instance i, given the inputs it sampled.
  function automatic void model_edge(int i, logic [7:0] c, bit v, bit rdy);
    bit pop, keep, brk, ext, held_before;
    logic [2:0] k;
    int idx;
    pop = (m_occ[i] > 0) && rdy;
    if (v) begin
      if (c == 8'hE0) begin
        m_ext[i] = 1; m_brk[i] = 0;
      end else if (c == 8'hF0) begin
        if (m_brk[i]) m_ext[i] = 0;
        m_brk[i] = 1;
      end else begin
        brk = m_brk[i]; ext = m_ext[i];
        m_brk[i] = 0; m_ext[i] = 0;
        k = ref_cmd(c);
        idx = int'(k) - 1;
        held_before = 0;
        if (k != 0) held_before = m_held[i][idx];
        keep = 1;
        if (brk && !cfg_eb[i]) keep = 0;
        if (k == 0 && cfg_co[i]) keep = 0;
        if (!brk && held_before && cfg_fr[i]) keep = 0;
        if (k != 0) m_held[i][idx] = !brk;
        if (!brk) m_last[i] = {7'h00, ext, c};
        if (keep) begin
          if (m_occ[i] < cfg_depth[i] || pop) begin
            if (i == 0) exp_q0.push_back({brk, ext, c, k});
            else        exp_q1.push_back({brk, ext, c, k});
            m_occ[i]++;
          end else begin
            m_ovf[i] = 1;
            if (m_cnt[i] < 255) m_cnt[i]++;
          end
        end
      end
    end
    if (pop) m_occ[i]--;
  endfunction

  function automatic void mon(int i, logic [12:0] d, logic v, logic r, logic [5:0] h,
                              logic [15:0] lc, logic o, logic [7:0] cnt);
    logic [12:0] e;
    chk($sformatf("ev_valid[%0d]", i), v, m_occ[i] != 0);
    chk($sformatf("held[%0d]", i), h, m_held[i]);
    chk($sformatf("last_code[%0d]", i), lc, m_last[i]);
    chk($sformatf("overflow[%0d]", i), o, m_ovf[i]);
    chk($sformatf("ovf_cnt[%0d]", i), cnt, m_cnt[i]);
    if (prev_hold[i]) chk($sformatf("ev_data_stable[%0d]", i), d, prev_d[i]);
    if (v === 1'b1 && r === 1'b1) begin
      hs_cnt[i]++;
      if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
        chk($sformatf("unexpected_event[%0d]", i), d, 13'h0000);
        if (d === 13'h0000) begin
          n_fail++;
          $display("FAIL unexpected_event[%0d]: got %0h expected none", i, d);
        end
      end else begin
        e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        chk($sformatf("ev_data[%0d]", i), d, e);
      end
    end
    prev_hold[i] = (v === 1'b1) && (r !== 1'b1);
    prev_d[i]    = d;
  endfunction

  always @(negedge clk50) begin
    if (!RST) begin
      mon(0, bus_a.ev_data, bus_a.ev_valid, bus_a.ev_ready, bus_a.held,
          bus_a.last_code, bus_a.overflow, bus_a.ovf_cnt);
      mon(1, bus_b.ev_data, bus_b.ev_valid, bus_b.ev_ready, bus_b.held,
          bus_b.last_code, bus_b.overflow, bus_b.ovf_cnt);
    end
  end

  task automatic step(input logic [7:0] c, input bit v, input bit r0, input bit r1);
    bus_a.code_in = c;  bus_b.code_in = c;
    bus_a.code_valid = v; bus_b.code_valid = v;
    bus_a.ev_ready = r0;  bus_b.ev_ready = r1;
    @(posedge clk50); #1;
    model_edge(0, c, v, r0);
    model_edge(1, c, v, r1);
  endtask

  task automatic send(input logic [7:0] c);
    step(c, 1'b1, rdy0, rdy1);
  endtask

  task automatic drain();
    rdy0 = 1; rdy1 = 1;
    repeat (12) step(8'h00, 1'b0, rdy0, rdy1);
    rdy0 = 0; rdy1 = 0;
  endtask

  // Called just after a rising edge; RST pulses well clear of the next edge.
  task automatic do_reset();
    RST = 1'b1;
    bus_a.code_valid = 0; bus_b.code_valid = 0;
    bus_a.ev_ready = 0;   bus_b.ev_ready = 0;
    #1;
    chk("rst_ev_valid_a", bus_a.ev_valid, 1'b0);
    chk("rst_ev_valid_b", bus_b.ev_valid, 1'b0);
    chk("rst_held_a", bus_a.held, 6'h00);
    chk("rst_last_b", bus_b.last_code, 16'h0000);
    chk("rst_ovf_cnt_b", bus_b.ovf_cnt, 8'h00);
    chk("rst_overflow_a", bus_a.overflow, 1'b0);
    model_reset();
    #1;
    RST = 1'b0;
  endtask

  logic [7:0] pool[16] = '{8'hE0, 8'hF0, 8'hE1, 8'h1D, 8'h75, 8'h1B, 8'h72, 8'h1C,
                           8'h6B, 8'h23, 8'h74, 8'h5A, 8'h76, 8'h1A, 8'h00, 8'hF0};

  initial begin
    int base0, base1, rprob;
    logic [7:0] c;
    bit v;
    rdy0 = 0; rdy1 = 0;
    bus_a.code_in = 0; bus_b.code_in = 0;
    bus_a.code_valid = 0; bus_b.code_valid = 0;
    bus_a.ev_ready = 0; bus_b.ev_ready = 0;
    @(posedge clk50); #1;
    do_reset();

    // Single make.
    send(8'h1D);
    chk("t1_held", bus_a.held, 6'b000001);
    chk("t1_last_code", bus_a.last_code, 16'h001D);
    chk("t1_ev_valid", bus_a.ev_valid, 1'b1);
    chk("t1_ev_data", bus_a.ev_data, {1'b0, 1'b0, 8'h1D, 3'd1});
    drain();
    send(8'hF0); send(8'h1D);
    drain();

    // Extended make and extended break.
    base0 = hs_cnt[0]; base1 = hs_cnt[1];
    send(8'hE0); send(8'h75);
    chk("t2_ev_data_b", bus_b.ev_data, {1'b0, 1'b1, 8'h75, 3'd1});
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("t2_held_b", bus_b.held, 6'b000000);
    chk("t2_last_code_b", bus_b.last_code, 16'h0175);
    drain();
    chk("t2_events_b", hs_cnt[1] - base1, 2);
    chk("t2_events_a", hs_cnt[0] - base0, 1);

    // Typematic repeat filtering.
    base0 = hs_cnt[0]; base1 = hs_cnt[1];
    rdy1 = 1;
    send(8'h5A); send(8'h5A); send(8'h5A);
    send(8'hF0); send(8'h5A);
    send(8'h5A);
    drain();
    chk("t3_enter_events_a", hs_cnt[0] - base0, 2);
    chk("t3_events_b", hs_cnt[1] - base1, 5);

    // Overflow on a DEPTH=4 queue.
    do_reset();
    send(8'h1D); send(8'h1B); send(8'h1C); send(8'h23); send(8'h5A); send(8'h76);
    chk("t4_overflow_b", bus_b.overflow, 1'b1);
    chk("t4_ovf_cnt_b", bus_b.ovf_cnt, 8'd2);
    chk("t4_overflow_a", bus_a.overflow, 1'b0);

    // Full with simultaneous push and pop.
    base1 = hs_cnt[1];
    step(8'h75, 1'b1, 1'b0, 1'b1);
    chk("t5_ovf_cnt_b", bus_b.ovf_cnt, 8'd2);
    chk("t5_ev_valid_b", bus_b.ev_valid, 1'b1);
    chk("t5_head_b", bus_b.ev_data, {1'b0, 1'b0, 8'h1B, 3'd2});
    drain();
    chk("t5_events_b", hs_cnt[1] - base1, 5);

    // Reset discards a pending prefix and a non-empty queue.
    send(8'h72);
    send(8'hE0);
    do_reset();
    base0 = hs_cnt[0];
    send(8'h1B);
    chk("t6_ev_data_a", bus_a.ev_data, {1'b0, 1'b0, 8'h1B, 3'd2});
    send(8'h1A);
    chk("t6_last_code_a", bus_a.last_code, 16'h001A);
    drain();
    chk("t6_events_a", hs_cnt[0] - base0, 1);

    // Overflow counter saturation.
    do_reset();
    repeat (300) begin
      send(8'h1D); send(8'hF0); send(8'h1D);
    end
    chk("t7_ovf_sat_b", bus_b.ovf_cnt, 8'hFF);
    chk("t7_ovf_sat_a", bus_a.ovf_cnt, 8'hFF);
    drain();

    // Randomized traffic with varying consumer pressure.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rprob = ((n / 500) % 2 == 0) ? 25 : 85;
      v = ($urandom_range(99) < 70);
      if ($urandom_range(4) == 0) c = 8'($urandom);
      else c = pool[$urandom_range(15)];
      step(c, v, $urandom_range(99) < rprob, $urandom_range(99) < rprob);
    end
    drain();
    drain();
    chk("leftover_a", exp_q0.size(), 0);
    chk("leftover_b", exp_q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_cmd_queue.md
# ps2_cmd_queue

Parametrised PS/2 key-event decoder and command queue placed between `keyboard` and the game/UI control logic. It turns the raw scan-code byte stream (make, `F0` break and `E0` extended prefixes) into complete key events. Each event is classified into a board-navigation command, typematic repeats are filtered out, and events are buffered in a FIFO drained through a valid/ready handshake. It also exports a held-key vector and a display word that drives `seven_segment` directly.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `EMIT_BREAK`, 0: 1 = break (release) events are also queued; 0 = only make events are queued.
- `FILTER_REPEAT`, 1: 1 = drop a make of a command key that is already held.
- `CMD_ONLY`, 1: 1 = drop events whose cmd = 0 (unmapped keys).

Ports:
- `clk50`  in  1  system clock.
- `RST`  in  1  asynchronous, active-high reset.
- `code_in`  in  8  scan-code byte from `keyboard`.
- `code_valid`  in  1  one-cycle strobe; `code_in` is valid in that cycle.
- `ev_data`  out  13  head event `{brk, ext, code[7:0], cmd[2:0]}`.
- `ev_valid`  out  1  FIFO is non-empty.
- `ev_ready`  in  1  consumer accepts the head event.
- `held`  out  6  held state of cmds 1..6; bit k-1 = cmd k.
- `last_code`  out  16  `{7'h00, ext, code}` of the last completed make event.
- `overflow`  out  1  sticky; set when an event is dropped because the FIFO is full.
- `ovf_cnt`  out  8  saturating count of events dropped on full.

## Operation
- Decoder FSM, advanced only on `code_valid`:
  - IDLE: `E0` → EXT; `F0` → BRK; any other byte completes a make event with ext=0.
  - EXT: `E0` → EXT; `F0` → EXT_BRK; any other byte completes a make event with ext=1.
  - BRK: completes a break event with ext=0.
  - EXT_BRK: completes a break event with ext=1.
  - From BRK or EXT_BRK, `E0` restarts to EXT and `F0` restarts to BRK; no event is produced.
  - Every completed event returns the FSM to IDLE.
  - `E1` is handled as an ordinary code byte.
- Command map, independent of ext: `1D`/`75` → 1 (up), `1B`/`72` → 2 (down), `1C`/`6B` → 3 (left), `23`/`74` → 4 (right), `5A` → 5 (enter), `76` → 6 (esc). Every other code maps to 0.
- Held vector: on a completed make with cmd k ≠ 0, `held[k-1]` is set; on a completed break with cmd k ≠ 0, it is cleared. This is updated regardless of any filtering.
- Filtering, applied in order:
  1. Break with `EMIT_BREAK`=0: dropped.
  2. cmd = 0 with `CMD_ONLY`=1: dropped.
  3. Make of cmd k with `held[k-1]`=1 before the event and `FILTER_REPEAT`=1: dropped.
- Filtered events never count as overflow.
- `last_code` updates on every completed make event, filtered or not.
- FIFO:
  - Push occurs when a surviving event completes.
  - Pop occurs on `ev_valid && ev_ready`.
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH; occupancy is a log2(DEPTH)+1-bit count.
  - `ev_data` always shows the head entry and is don't-care when empty.
  - Full with push and no pop: the event is dropped, `overflow` is set, and `ovf_cnt` increments, saturating at 255.
  - Full with simultaneous push and pop: both occur and occupancy stays at DEPTH.
  - Empty with push: no bypass; the new event appears on `ev_data` the following cycle.

## Timing
- All state updates on the rising edge of `clk50`. `RST` clears asynchronously: FSM = IDLE, pointers and count = 0, `ev_valid`=0, `held`=0, `last_code`=0, `overflow`=0, `ovf_cnt`=0. Reset takes effect immediately, including mid-sequence after `E0`/`F0` and with a non-empty FIFO.
- Latency: the completing byte is sampled at edge N. `ev_valid`, `held` and `last_code` reflect it after edge N; `ev_valid` is 1 in cycle N+1.
- Throughput: one push and one pop per cycle. At most one event can complete per cycle because at most one byte arrives per cycle.
- `ev_data` must stay stable while `ev_valid && !ev_ready`.
- `ev_ready` asserted while `ev_valid`=0 has no effect.

## Test plan
- `code_in` = `1D` → one event `{0,0,1D,1}`; `held`=6'b000001; `last_code`=16'h001D.
- Byte sequence `E0 75`, `E0 F0 75`, with `EMIT_BREAK`=1 → events `{0,1,75,1}` then `{1,1,75,1}`; `held` returns to 0; `last_code`=16'h0175.
- `5A` ×3, then `F0 5A`, then `5A`, with `FILTER_REPEAT`=1 and `EMIT_BREAK`=0 → exactly two enter events are queued.
- `DEPTH`=4, `ev_ready`=0, six distinct command makes → 4 events queued, `overflow`=1, `ovf_cnt`=2. Then drain → cmds 1,2,3,4 in order.
- Full FIFO with `ev_ready`=1 and a new make arriving in the same cycle → occupancy stays 4, `ovf_cnt` unchanged, FIFO order preserved.
- `E0`, then `RST` pulse, then `1B` → event `{0,0,1B,2}`, i.e. ext=0 because the prefix was discarded. Code `1A` with `CMD_ONLY`=1 → no event, but `last_code`=16'h001A.
